// File: rtl/gpia_port.sv
// W-bit general-purpose I/O port: direction, output latch, synchronised inputs,
// sticky edge-capture flags with a maskable interrupt, and strobe-gated readback.
module gpia_port #(
    parameter int W        = 8,
    parameter int EDGE_SEL = 0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [1:0]   adr_i,
    input  logic [W-1:0] dat_i,
    input  logic         we_i,
    input  logic         stb_i,
    output logic [W-1:0] dat_o,
    input  logic [W-1:0] port_i,
    output logic [W-1:0] port_o,
    output logic [W-1:0] oe_o,
    output logic         int_o
);

    logic [W-1:0] out_q;
    logic [W-1:0] ddr_q;
    logic [W-1:0] edge_q;
    logic [W-1:0] imask_q;
    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s3_q;
    logic         primed_q;
    logic [1:0]   prime_cnt_q;

    logic         wr_en;
    logic [W-1:0] edge_evt;
    logic [W-1:0] edge_clr;

    assign wr_en = stb_i && we_i;

    // primed rises only once s3 holds a post-reset sample, so levels present at
    // reset are never compared against the zeroed stages.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            primed_q    <= 1'b0;
            prime_cnt_q <= 2'd0;
        end else begin
            s1_q <= port_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (!primed_q) begin
                if (prime_cnt_q == 2'd2) begin
                    primed_q <= 1'b1;
                end else begin
                    prime_cnt_q <= prime_cnt_q + 2'd1;
                end
            end
        end
    end

    always_comb begin
        edge_evt = '0;
        case (EDGE_SEL)
            1:       edge_evt = s2_q & ~s3_q;
            2:       edge_evt = ~s2_q & s3_q;
            default: edge_evt = s2_q ^ s3_q;
        endcase
        edge_evt = edge_evt & ~ddr_q & {W{primed_q}};
    end

    assign edge_clr = (wr_en && adr_i == 2'd2) ? dat_i : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_q   <= '0;
            ddr_q   <= '0;
            edge_q  <= '0;
            imask_q <= '0;
        end else begin
            if (wr_en && adr_i == 2'd0) out_q   <= dat_i;
            if (wr_en && adr_i == 2'd1) ddr_q   <= dat_i;
            if (wr_en && adr_i == 2'd3) imask_q <= dat_i;
            // A new event outranks a same-cycle clear of that bit.
            edge_q <= (edge_q & ~edge_clr) | edge_evt;
        end
    end

    always_comb begin
        dat_o = '0;
        if (stb_i && !we_i) begin
            case (adr_i)
                2'd0:    dat_o = (ddr_q & out_q) | (~ddr_q & s2_q);
                2'd1:    dat_o = ddr_q;
                2'd2:    dat_o = edge_q;
                default: dat_o = imask_q;
            endcase
        end
    end

    assign port_o = out_q;
    assign oe_o   = ddr_q;
    assign int_o  = |(edge_q & imask_q);

endmodule
